field_reader: RTL and testbench

Streaming reader for the vector-field BRAM: on `start`, scans every cell in raster order through the BRAM's registered read port. Each word is split into `{xn, yn, mag}` and presented with its cell coordinates on a valid/ready output stream. It sits downstream of the field-update engine, as the read-side consumer of the same field memory that engine writes. It feeds the arrow/colour renderer and any debug dump path, with full-throughput operation and lossless backpressure.

---
 rtl/field_reader.sv | 200 ++++++++++++++++++++
 tb/tb_field_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_reader.sv
// field_reader: streams every cell of the vector-field BRAM in raster order as
// {x, y, xn, yn, mag} elements on a valid/ready output with lossless backpressure.
module field_reader #(
   parameter int  FIELD_WIDTH  = 8,
   parameter int  FIELD_HEIGHT = 6,
   parameter int  FIELD_DATAW  = 96,
   localparam int FIELD_ADDRW  = $clog2(FIELD_WIDTH * FIELD_HEIGHT)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic [FIELD_ADDRW-1:0]        field_addr_read,
   input  logic [FIELD_DATAW-1:0]        field_data_out,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [31:0]                   out_x,
   output logic [31:0]                   out_y,
   output logic signed [31:0]            out_xn,
   output logic signed [31:0]            out_yn,
   output logic signed [31:0]            out_mag,
   output logic                          out_last
);

   localparam int CELLS = FIELD_WIDTH * FIELD_HEIGHT;
   localparam int XW    = (FIELD_WIDTH > 1) ? $clog2(FIELD_WIDTH) : 1;
   localparam int YW    = (FIELD_HEIGHT > 1) ? $clog2(FIELD_HEIGHT) : 1;
   localparam logic [FIELD_ADDRW-1:0] LAST_IDX = FIELD_ADDRW'(CELLS - 1);
   localparam logic [XW-1:0]          X_LAST   = XW'(FIELD_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN
   } state_t;

   typedef struct packed {
      logic [XW-1:0]          x;
      logic [YW-1:0]          y;
      logic                   last;
      logic [FIELD_DATAW-1:0] word;
   } entry_t;

   state_t                 state_reg, state_next;
   logic [FIELD_ADDRW-1:0] idx_reg, idx_next;
   logic [XW-1:0]          x_reg, x_next;
   logic [YW-1:0]          y_reg, y_next;
   logic                   inflight_reg, inflight_next;
   logic [XW-1:0]          tag_x_reg, tag_x_next;
   logic [YW-1:0]          tag_y_reg, tag_y_next;
   logic                   tag_last_reg, tag_last_next;
   logic                   done_reg, done_next;
   logic [1:0]             count_reg, count_next;

   logic                   pop;
   logic                   push;
   logic                   clear;
   logic                   issue_room;
   logic [1:0]             wr_pos;
   entry_t                 push_entry;
   entry_t [1:0]           fifo_q;
   entry_t                 head;

   assign head       = fifo_q[0];
   assign out_valid  = (count_reg != 2'd0);
   assign pop        = out_valid & out_ready;
   assign push       = inflight_reg;
   assign wr_pos     = count_reg - {1'b0, pop};
   // Words already queued plus the one in the BRAM pipe must fit the 2-deep FIFO.
   assign issue_room = (int'(count_reg) + int'(inflight_reg) - int'(pop)) < 2;

   assign push_entry = '{x: tag_x_reg, y: tag_y_reg, last: tag_last_reg, word: field_data_out};

   assign field_addr_read = idx_reg;
   assign busy            = (state_reg != ST_IDLE);
   assign done            = done_reg;
   assign out_x           = 32'(head.x);
   assign out_y           = 32'(head.y);
   assign out_xn          = head.word[95:64];
   assign out_yn          = head.word[63:32];
   assign out_mag         = head.word[31:0];
   assign out_last        = head.last & out_valid;

   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      x_next        = x_reg;
      y_next        = y_reg;
      inflight_next = 1'b0;
      tag_x_next    = tag_x_reg;
      tag_y_next    = tag_y_reg;
      tag_last_next = tag_last_reg;
      done_next     = 1'b0;
      clear         = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_FETCH;
               idx_next   = '0;
               x_next     = '0;
               y_next     = '0;
               clear      = 1'b1;
            end
         end
         ST_FETCH: begin
            if (issue_room) begin
               inflight_next = 1'b1;
               tag_x_next    = x_reg;
               tag_y_next    = y_reg;
               tag_last_next = (idx_reg == LAST_IDX);
               if (idx_reg == LAST_IDX) begin
                  // Park the index at 0 so the idle address is already correct.
                  state_next = ST_DRAIN;
                  idx_next   = '0;
                  x_next     = '0;
                  y_next     = '0;
               end else begin
                  idx_next = idx_reg + FIELD_ADDRW'(1);
                  if (x_reg == X_LAST) begin
                     x_next = '0;
                     y_next = y_reg + YW'(1);
                  end else begin
                     x_next = x_reg + XW'(1);
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (pop && head.last) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      if (clear) begin
         count_next = 2'd0;
      end else begin
         count_next = count_reg + {1'b0, push} - {1'b0, pop};
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         entry_t entry_reg, entry_next;

         // Entry 0 is always the head; a pop shifts entry 1 down.
         always_comb begin
            entry_next = entry_reg;
            if (push && (wr_pos == 2'(gi))) begin
               entry_next = push_entry;
            end else if (pop && (gi == 0)) begin
               entry_next = fifo_q[1];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               entry_reg <= '0;
            end else begin
               entry_reg <= entry_next;
            end
         end

         assign fifo_q[gi] = entry_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         idx_reg      <= '0;
         x_reg        <= '0;
         y_reg        <= '0;
         inflight_reg <= 1'b0;
         tag_x_reg    <= '0;
         tag_y_reg    <= '0;
         tag_last_reg <= 1'b0;
         done_reg     <= 1'b0;
         count_reg    <= 2'd0;
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         x_reg        <= x_next;
         y_reg        <= y_next;
         inflight_reg <= inflight_next;
         tag_x_reg    <= tag_x_next;
         tag_y_reg    <= tag_y_next;
         tag_last_reg <= tag_last_next;
         done_reg     <= done_next;
         count_reg    <= count_next;
      end
   end

endmodule

// File: tb/tb_field_reader.sv
// Self-checking bench for field_reader: BRAM model, reference element queue,
// full-rate, backpressure, start-while-busy, mid-scan reset and back-to-back scans.
module tb_field_reader;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int N  = W * H;
   localparam int AW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          busy;
   logic          done;
   logic [AW-1:0] field_addr_read;
   logic [95:0]   field_data_out;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_x;
   logic [31:0]   out_y;
   logic signed [31:0] out_xn;
   logic signed [31:0] out_yn;
   logic signed [31:0] out_mag;
   logic          out_last;

   logic [95:0]   mem [N];
   logic [191:0]  exp_q [$];

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int pops         = 0;
   int done_cnt     = 0;
   int done_cyc     = -1;
   int first_cyc    = -1;
   int t_start      = 0;
   int ready_mode   = 0;

   field_reader dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .field_addr_read (field_addr_read),
      .field_data_out  (field_data_out),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_x           (out_x),
      .out_y           (out_y),
      .out_xn          (out_xn),
      .out_yn          (out_yn),
      .out_mag         (out_mag),
      .out_last        (out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered-read BRAM, one cycle of latency
   always @(posedge clk) field_data_out <= mem[field_addr_read];

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [191:0] pack_out();
      return {30'd0, out_valid, out_last, out_x, out_y, out_xn, out_yn, out_mag};
   endfunction

   function automatic logic [191:0] ref_elem(input int i);
      logic [191:0] r;
      r          = '0;
      r[161]     = 1'b1;
      r[160]     = (i == N - 1);
      r[159:128] = 32'(i % W);
      r[127:96]  = 32'(i / W);
      r[95:0]    = mem[i];
      return r;
   endfunction

   task automatic load_mem(input bit rnd);
      for (int i = 0; i < N; i++) begin
         if (rnd) mem[i] = {$urandom, $urandom, $urandom};
         else     mem[i] = {32'(i), 32'(-i), 32'(3 * i)};
      end
   endtask

   task automatic arm_expect();
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back(ref_elem(i));
      pops      = 0;
      done_cnt  = 0;
      done_cyc  = -1;
      first_cyc = -1;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start   = 1'b1;
      t_start = cyc;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (done_cnt == 0 && k < 3000) begin
         @(negedge clk); #1;
         k++;
      end
      check("done_seen", 192'(done_cnt != 0), 192'(1));
      repeat (8) @(negedge clk);
      #1;
      check("elem_count", 192'(pops), 192'(N));
      check("done_count", 192'(done_cnt), 192'(1));
      check("idle_after", 192'({busy, out_valid}), 192'(0));
   endtask

   // Output monitor: scoreboard compare on every handshake, hold-stability on stalls
   logic [191:0] held;
   logic [191:0] cur;
   logic [191:0] want;
   bit           held_v = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         held_v = 1'b0;
      end else begin
         cur = pack_out();
         if (held_v) check("hold_stable", cur, held);
         if (out_valid && out_ready) begin
            if (first_cyc < 0) first_cyc = cyc;
            $display("[TB] elem x=%0d y=%0d xn=%0d yn=%0d mag=%0d last=%0b",
                     out_x, out_y, out_xn, out_yn, out_mag, out_last);
            if (exp_q.size() == 0) begin
               check("extra_elem", 192'(1), 192'(0));
            end else begin
               want = exp_q.pop_front();
               check($sformatf("elem%0d", pops), cur, want);
            end
            pops++;
         end
         held_v = out_valid && !out_ready;
         held   = cur;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   initial begin
      int ph;
      ph        = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
               out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
               ph++;
            end
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      int k;
      rst_n = 1'b0;
      start = 1'b0;
      load_mem(1'b0);

      // Reset and quiet idle
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            192'({busy, done, out_valid, out_last, field_addr_read, out_x, out_y, out_xn, out_yn, out_mag}),
            192'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_quiet", 192'({out_valid, busy, field_addr_read}), 192'(0));
      end

      // Full-rate scan
      arm_expect();
      pulse_start();
      @(negedge clk);
      check("fetch_T1", 192'({busy, field_addr_read}), 192'({1'b1, {AW{1'b0}}}));
      wait_done();
      check("first_latency", 192'(first_cyc), 192'(t_start + 3));
      check("done_cycle", 192'(done_cyc), 192'(t_start + N + 3));

      // Backpressure 1,0,0,1
      ready_mode = 1;
      arm_expect();
      pulse_start();
      wait_done();

      // Start while busy, random contents and random ready
      load_mem(1'b1);
      ready_mode = 2;
      arm_expect();
      pulse_start();
      repeat ($urandom_range(5, 30)) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();

      // Reset mid-scan
      load_mem(1'b0);
      ready_mode = 0;
      arm_expect();
      pulse_start();
      k = 0;
      while (pops < 21 && k < 500) begin
         @(negedge clk); #1;
         k++;
      end
      check("reached_elem20", 192'(pops >= 21), 192'(1));
      rst_n = 1'b0;
      #1;
      check("async_drop", 192'({out_valid, busy, field_addr_read}), 192'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      arm_expect();
      pulse_start();
      wait_done();
      check("restart_latency", 192'(first_cyc), 192'(t_start + 3));

      // Back-to-back: second start in the done cycle
      load_mem(1'b1);
      arm_expect();
      pulse_start();
      k = 0;
      while (done_cnt == 0 && k < 3000) begin
         @(negedge clk); #1;
         k++;
      end
      check("b2b_first_done", 192'(done_cnt), 192'(1));
      check("b2b_first_count", 192'(pops), 192'(N));
      start   = 1'b1;
      t_start = cyc;
      arm_expect();
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      check("b2b_latency", 192'(first_cyc), 192'(t_start + 3));
      check("b2b_done_cycle", 192'(done_cyc), 192'(t_start + N + 3));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
